// File: rtl/uc_pkg.sv
// Shared types and constants for the multi-cycle microcontroller control unit.
// Holds the FSM state encoding, the special opcodes and the error codes.
package uc_pkg;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_IO_WAIT = 3'd3,
    S_HALT    = 3'd4,
    S_ERR     = 3'd5
  } state_e;

  localparam logic [5:0] OP_JMP  = 6'b110000;
  localparam logic [5:0] OP_JZ   = 6'b110001;
  localparam logic [5:0] OP_JNZ  = 6'b110010;
  localparam logic [5:0] OP_CALL = 6'b110100;
  localparam logic [5:0] OP_RET  = 6'b110101;
  localparam logic [5:0] OP_IN   = 6'b111000;
  localparam logic [5:0] OP_OUT  = 6'b111001;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

endpackage

// File: rtl/uc_io_hs.sv
// I/O handshake: port select, strobes and ready lookup for the control unit.
// Optional wait timeout is built only when UC_IO_TIMEOUT_EN is defined.
module uc_io_hs
  import uc_pkg::*;
#(
  parameter int NPORTS         = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(NPORTS)-1:0] port_idx_i,
  input  logic [NPORTS-1:0]         io_rdy_i,
  input  logic                      rd_req_i,
  input  logic                      wr_req_i,
  input  logic                      wait_i,
  output logic                      io_rd_o,
  output logic                      io_wr_o,
  output logic [NPORTS-1:0]         io_sel_o,
  output logic                      rdy_o,
  output logic                      timeout_o
);

  localparam int PW = $clog2(NPORTS);

  logic [PW-1:0]     idx;
  logic [NPORTS-1:0] one_hot;

  // out-of-range port numbers fall back to port 0
  assign idx = ({{(32-PW){1'b0}}, port_idx_i} < 32'(NPORTS))
             ? port_idx_i : '0;

  assign one_hot  = {{(NPORTS-1){1'b0}}, 1'b1} << idx;
  assign io_sel_o = (rd_req_i | wr_req_i) ? one_hot : '0;
  assign io_rd_o  = rd_req_i;
  assign io_wr_o  = wr_req_i;
  assign rdy_o    = io_rdy_i[idx];

`ifdef UC_IO_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // zero outside the wait state, so every wait starts from a clean count
  always_comb begin
    cnt_d = wait_i ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign timeout_o = wait_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, reset, wait_i};
  assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/uc_mc_io.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC FSM, call stack depth and I/O.
// Define UC_IO_TIMEOUT_EN to bound the I/O wait with TIMEOUT_CYCLES.
module uc_mc_io
  import uc_pkg::*;
#(
  parameter int NPORTS         = 4,
  parameter int STACK_DEPTH    = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [5:0]                opcode,
  input  logic                      s_z,
  input  logic [$clog2(NPORTS)-1:0] port_idx,
  input  logic [NPORTS-1:0]         io_rdy,
  output logic                      ir_en,
  output logic                      pc_en,
  output logic                      s_inc,
  output logic                      s_inm,
  output logic                      s_in,
  output logic                      we3,
  output logic                      wez,
  output logic                      wesp,
  output logic                      push,
  output logic                      pop,
  output logic [2:0]                op_alu,
  output logic                      io_rd,
  output logic                      io_wr,
  output logic [NPORTS-1:0]         io_sel,
  output logic                      halted,
  output logic [1:0]                err
);

  localparam int SW = $clog2(STACK_DEPTH + 1);

  state_e        state_q, state_d;
  logic [SW-1:0] sp_q, sp_d;
  logic [1:0]    err_q, err_d;
  logic          is_in, is_out, io_act;
  logic          rdy, timeout;

  assign is_in  = (opcode == OP_IN);
  assign is_out = (opcode == OP_OUT);
  assign io_act = !reset &&
                  (state_q == S_EXEC || state_q == S_IO_WAIT);

  uc_io_hs #(
    .NPORTS         (NPORTS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_hs (
    .clk        (clk),
    .reset      (reset),
    .port_idx_i (port_idx),
    .io_rdy_i   (io_rdy),
    .rd_req_i   (io_act && is_in),
    .wr_req_i   (io_act && is_out),
    .wait_i     (state_q == S_IO_WAIT),
    .io_rd_o    (io_rd),
    .io_wr_o    (io_wr),
    .io_sel_o   (io_sel),
    .rdy_o      (rdy),
    .timeout_o  (timeout)
  );

  assign err = reset ? ERR_NONE : err_q;

  always_comb begin
    ir_en   = 1'b0;
    pc_en   = 1'b0;
    s_inc   = 1'b0;
    s_inm   = 1'b0;
    s_in    = 1'b0;
    we3     = 1'b0;
    wez     = 1'b0;
    wesp    = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    op_alu  = 3'b000;
    halted  = 1'b0;
    state_d = state_q;
    sp_d    = sp_q;
    err_d   = err_q;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          ir_en   = 1'b1;
          state_d = S_DECODE;
        end
        S_DECODE: state_d = S_EXEC;
        S_EXEC: begin
          unique case (1'b1)
            !opcode[5]: begin
              op_alu  = opcode[4:2];
              we3     = 1'b1;
              wez     = 1'b1;
              s_inc   = 1'b1;
              pc_en   = 1'b1;
              state_d = S_FETCH;
            end
            opcode[5:4] == 2'b10: begin
              s_inm   = 1'b1;
              we3     = 1'b1;
              s_inc   = 1'b1;
              pc_en   = 1'b1;
              state_d = S_FETCH;
            end
            opcode == OP_JMP,
            opcode == OP_JZ,
            opcode == OP_JNZ: begin
              s_inc   = (opcode == OP_JZ)  ? ~s_z :
                        (opcode == OP_JNZ) ?  s_z : 1'b0;
              pc_en   = 1'b1;
              state_d = S_FETCH;
            end
            opcode == OP_CALL: begin
              if (sp_q == SW'(STACK_DEPTH)) begin
                err_d   = ERR_OVF;
                state_d = S_ERR;
              end else begin
                wesp    = 1'b1;
                push    = 1'b1;
                pc_en   = 1'b1;
                sp_d    = sp_q + 1'b1;
                state_d = S_FETCH;
              end
            end
            opcode == OP_RET: begin
              if (sp_q == '0) begin
                err_d   = ERR_UNF;
                state_d = S_ERR;
              end else begin
                wesp    = 1'b1;
                pop     = 1'b1;
                pc_en   = 1'b1;
                sp_d    = sp_q - 1'b1;
                state_d = S_FETCH;
              end
            end
            is_in || is_out: begin
              if (rdy) begin
                s_in    = is_in;
                we3     = is_in;
                pc_en   = 1'b1;
                s_inc   = 1'b1;
                state_d = S_FETCH;
              end else begin
                state_d = S_IO_WAIT;
              end
            end
            default: state_d = S_HALT;
          endcase
        end
        S_IO_WAIT: begin
          // ready wins over a timeout landing in the same cycle
          if (rdy) begin
            s_in    = is_in;
            we3     = is_in;
            pc_en   = 1'b1;
            s_inc   = 1'b1;
            state_d = S_FETCH;
          end else if (timeout) begin
            err_d   = ERR_TMO;
            state_d = S_ERR;
          end
        end
        S_HALT, S_ERR: halted = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      sp_q    <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_uc_mc_io.sv
// Randomised scoreboard bench for uc_mc_io against an instruction-level model.
// Define UC_IO_TIMEOUT_EN to also exercise the I/O wait timeout.
module tb_uc_mc_io;
  import uc_pkg::*;

  localparam int NP = 6;
  localparam int PW = $clog2(NP);
  localparam int SD = 2;
  localparam int TO = 10;

  typedef struct packed {
    logic          ir_en;
    logic          pc_en;
    logic          s_inc;
    logic          s_inm;
    logic          s_in;
    logic          we3;
    logic          wez;
    logic          wesp;
    logic          push;
    logic          pop;
    logic [2:0]    op_alu;
    logic          io_rd;
    logic          io_wr;
    logic [NP-1:0] io_sel;
    logic          halted;
    logic [1:0]    err;
  } out_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    opcode = '0;
  logic          s_z = 1'b0;
  logic [PW-1:0] port_idx = '0;
  logic [NP-1:0] io_rdy = '0;
  logic          ir_en, pc_en, s_inc, s_inm, s_in, we3, wez;
  logic          wesp, push, pop, io_rd, io_wr, halted;
  logic [2:0]    op_alu;
  logic [NP-1:0] io_sel;
  logic [1:0]    err;

  uc_mc_io #(
    .NPORTS         (NP),
    .STACK_DEPTH    (SD),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .s_z      (s_z),
    .port_idx (port_idx),
    .io_rdy   (io_rdy),
    .ir_en    (ir_en),
    .pc_en    (pc_en),
    .s_inc    (s_inc),
    .s_inm    (s_inm),
    .s_in     (s_in),
    .we3      (we3),
    .wez      (wez),
    .wesp     (wesp),
    .push     (push),
    .pop      (pop),
    .op_alu   (op_alu),
    .io_rd    (io_rd),
    .io_wr    (io_wr),
    .io_sel   (io_sel),
    .halted   (halted),
    .err      (err)
  );

  always #5 clk = ~clk;

  out_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad = 0;

  // model state: call depth, stopped flag, latched error code
  int         m_sp = 0;
  bit         m_stop = 0;
  logic [1:0] m_err = 2'b00;
  int         icnt = 0;

  always @(negedge clk) begin
    out_t  a, e;
    string t;
    if (exp_q.size() > 0) begin
      a = {ir_en, pc_en, s_inc, s_inm, s_in, we3, wez, wesp,
           push, pop, op_alu, io_rd, io_wr, io_sel, halted, err};
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got %h want %h", t, a, e);
      end
    end
  end

  task automatic cyc(input logic rst, input logic [5:0] op,
                     input logic sz, input logic [PW-1:0] pi,
                     input logic [NP-1:0] rdy, input out_t e,
                     input string ph);
    @(posedge clk);
    #1;
    reset    = rst;
    opcode   = op;
    s_z      = sz;
    port_idx = pi;
    io_rdy   = rdy;
    exp_q.push_back(e);
    tag_q.push_back($sformatf("i%0d_op%b_%s", icnt, op, ph));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b1, 6'($urandom), 1'($urandom), PW'($urandom),
          NP'($urandom), '0, "reset");
    m_sp   = 0;
    m_stop = 0;
    m_err  = 2'b00;
  endtask

  // one instruction: expected outputs derived from the opcode rules
  task automatic instr(input logic [5:0] op, input logic sz,
                       input logic [PW-1:0] pi, input int dly,
                       input int abort);
    out_t          e;
    logic [NP-1:0] r;
    int            p;
    bit            is_io;
    icnt++;
    p = (int'(pi) < NP) ? int'(pi) : 0;
    if (m_stop) begin
      for (int i = 0; i < 3; i++) begin
        e = '0;
        e.halted = 1'b1;
        e.err = m_err;
        cyc(1'b0, op, sz, pi, NP'($urandom), e, "stopped");
      end
      return;
    end
    e = '0;
    e.ir_en = 1'b1;
    cyc(1'b0, op, sz, pi, NP'($urandom), e, "fetch");
    cyc(1'b0, op, sz, pi, NP'($urandom), '0, "decode");
    is_io = (op == OP_IN) || (op == OP_OUT);
    if (!is_io) begin
      e = '0;
      if (op[5] == 1'b0) begin
        e.op_alu = op[4:2];
        e.we3 = 1'b1; e.wez = 1'b1; e.s_inc = 1'b1; e.pc_en = 1'b1;
      end else if (op[5:4] == 2'b10) begin
        e.s_inm = 1'b1; e.we3 = 1'b1; e.s_inc = 1'b1; e.pc_en = 1'b1;
      end else if (op == OP_JMP) begin
        e.pc_en = 1'b1;
      end else if (op == OP_JZ) begin
        e.pc_en = 1'b1; e.s_inc = ~sz;
      end else if (op == OP_JNZ) begin
        e.pc_en = 1'b1; e.s_inc = sz;
      end else if (op == OP_CALL && m_sp < SD) begin
        e.pc_en = 1'b1; e.wesp = 1'b1; e.push = 1'b1;
      end else if (op == OP_RET && m_sp > 0) begin
        e.pc_en = 1'b1; e.wesp = 1'b1; e.pop = 1'b1;
      end
      cyc(1'b0, op, sz, pi, NP'($urandom), e, "exec");
      if (op == OP_CALL) begin
        if (m_sp == SD) begin m_stop = 1; m_err = 2'b01; end
        else m_sp++;
      end else if (op == OP_RET) begin
        if (m_sp == 0) begin m_stop = 1; m_err = 2'b10; end
        else m_sp--;
      end else if (op[5:4] == 2'b11 && op != OP_JMP &&
                   op != OP_JZ && op != OP_JNZ) begin
        m_stop = 1;
      end
      return;
    end
    for (int k = 0; k < 100000; k++) begin
      if (k == abort) begin
        do_reset(1);
        return;
      end
      r = NP'($urandom);
      r[p] = (k == dly);
      e = '0;
      e.io_rd  = (op == OP_IN);
      e.io_wr  = (op == OP_OUT);
      e.io_sel = NP'(1) << p;
      if (k == dly) begin
        e.pc_en = 1'b1; e.s_inc = 1'b1;
        e.s_in = (op == OP_IN); e.we3 = (op == OP_IN);
        cyc(1'b0, op, sz, pi, r, e, "io_done");
        return;
      end
      cyc(1'b0, op, sz, pi, r, e, "io_wait");
`ifdef UC_IO_TIMEOUT_EN
      if (k == TO) begin
        m_stop = 1;
        m_err  = 2'b11;
        return;
      end
`endif
    end
  endtask

  function automatic logic [5:0] rnd_op();
    logic [5:0] o;
    case ($urandom_range(0, 19))
      0, 1, 2, 3, 4, 5: o = {1'b0, 5'($urandom)};
      6, 7:   o = {2'b10, 4'($urandom)};
      8:      o = OP_JMP;
      9:      o = OP_JZ;
      10:     o = OP_JNZ;
      11, 12: o = OP_CALL;
      13, 14: o = OP_RET;
      15, 16: o = OP_IN;
      17:     o = OP_OUT;
      18:     o = OP_HALT;
      default: begin
        do o = {2'b11, 4'($urandom)};
        while (o inside {OP_JMP, OP_JZ, OP_JNZ, OP_CALL,
                         OP_RET, OP_IN, OP_OUT});
      end
    endcase
    return o;
  endfunction

  initial begin
    int dly;
    int ab;
    do_reset(2);
    instr(6'b000100, 1'b0, 3'd0, 0, -1);
    instr(OP_JZ, 1'b1, 3'd0, 0, -1);
    instr(OP_JZ, 1'b0, 3'd0, 0, -1);
    instr(OP_JNZ, 1'b1, 3'd0, 0, -1);
    instr(6'b101010, 1'b0, 3'd0, 0, -1);
    instr(OP_CALL, 1'b0, 3'd0, 0, -1);
    instr(OP_CALL, 1'b0, 3'd0, 0, -1);
    instr(OP_CALL, 1'b0, 3'd0, 0, -1);
    instr(6'b000000, 1'b0, 3'd0, 0, -1);
    do_reset(1);
    instr(OP_RET, 1'b0, 3'd0, 0, -1);
    instr(OP_JMP, 1'b0, 3'd0, 0, -1);
    do_reset(1);
    instr(OP_IN, 1'b0, 3'd2, 5, -1);
    instr(OP_OUT, 1'b0, 3'd7, 2, -1);
    instr(OP_IN, 1'b0, 3'd6, 0, -1);
`ifdef UC_IO_TIMEOUT_EN
    instr(OP_OUT, 1'b0, 3'd1, 1000, -1);
`else
    instr(OP_OUT, 1'b0, 3'd1, 300, -1);
`endif
    instr(6'b011100, 1'b0, 3'd0, 0, -1);
    do_reset(1);
    instr(OP_IN, 1'b0, 3'd3, 1000, 4);
    instr(6'b010000, 1'b0, 3'd0, 0, -1);
    instr(6'b110011, 1'b0, 3'd0, 0, -1);
    instr(OP_IN, 1'b0, 3'd0, 0, -1);
    do_reset(1);
    for (int n = 0; n < 300; n++) begin
      dly = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 14)
                                         : $urandom_range(0, 6);
      ab  = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 5) : -1;
      instr(rnd_op(), 1'($urandom), PW'($urandom), dly, ab);
      if (m_stop && $urandom_range(0, 2) == 0)
        do_reset($urandom_range(1, 2));
    end
    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uc_mc_io.md
UC_MC_IO -- requirements
Module: uc_mc_io

Interface
REQ-001 The module SHALL have parameter NPORTS, default 4, giving the number of I/O ports (2..16).
REQ-002 The module SHALL have parameter STACK_DEPTH, default 8, giving the number of return-address entries tracked (1..64).
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 255, giving the I/O wait limit; it is used only with UC_IO_TIMEOUT_EN.
REQ-004 Ports (clock and reset first):
 clk  in  1  single clock; one clock only, all state on its rising edge
 reset  in  1  synchronous, active-high reset
 opcode  in  6  instruction opcode field from the instruction register
 s_z  in  1  ALU zero flag
 port_idx  in  clog2(NPORTS)  I/O port number from the instruction
 io_rdy  in  NPORTS  per-port ready/valid from the I/O devices
 ir_en  out  1  load the instruction register
 pc_en  out  1  update the PC
 s_inc  out  1  PC source: 1 = PC+1, 0 = jump target
 s_inm  out  1  register-file write source: 1 = immediate
 s_in  out  1  register-file write source: 1 = I/O input data
 we3  out  1  register-file write enable
 wez  out  1  zero-flag write enable
 wesp  out  1  stack write enable
 push  out  1  stack push
 pop  out  1  stack pop
 op_alu  out  3  ALU operation
 io_rd  out  1  input strobe, held until the handshake completes
 io_wr  out  1  output strobe, held until the handshake completes
 io_sel  out  NPORTS  one-hot port select, valid while io_rd or io_wr is high
 halted  out  1  core is stopped (HALT or ERR state)
 err  out  2  error code: 00 none, 01 stack overflow, 10 stack underflow, 11 I/O timeout

Function
REQ-005 The FSM SHALL have the states FETCH, DECODE, EXEC, IO_WAIT, HALT and ERR.
REQ-006 FETCH SHALL assert ir_en for 1 cycle and then go to DECODE; DECODE SHALL assert nothing and go to EXEC.
REQ-007 In EXEC, pc_en SHALL be high for exactly 1 cycle and the state SHALL return to FETCH; a non-I/O instruction therefore takes 3 cycles.
REQ-008 Opcode 00xxxx/01xxxx (ALU) SHALL give, in EXEC: op_alu=opcode[4:2], we3=1, wez=1, s_inc=1.
REQ-009 Opcode 10xxxx (load immediate) SHALL give, in EXEC: s_inm=1, we3=1, s_inc=1.
REQ-010 Jumps SHALL give, in EXEC:
 - 110000 (jump): s_inc=0
 - 110001 (jump if zero): s_inc=~s_z
 - 110010 (jump if not zero): s_inc=s_z
REQ-011 Opcode 110100 (call) SHALL give, in EXEC: wesp=1, push=1, s_inc=0, and SHALL increment sp_cnt.
REQ-012 Opcode 110101 (return) SHALL give, in EXEC: wesp=1, pop=1, s_inc=0, and SHALL decrement sp_cnt.
REQ-013 A call with sp_cnt==STACK_DEPTH SHALL go to ERR with err=01, with push, wesp and pc_en low.
REQ-014 A return with sp_cnt==0 SHALL go to ERR with err=10, with pop, wesp and pc_en low.
REQ-015 Opcode 111000 (IN) SHALL set, in EXEC: io_rd=1 and io_sel=1<<port_idx.
 - If io_rdy[port_idx]=1 in that cycle: also s_in=1, we3=1, pc_en=1, s_inc=1, then go to FETCH.
 - Otherwise: go to IO_WAIT with io_rd held high.
REQ-016 Opcode 111001 (OUT) SHALL behave the same as IN, using io_wr, with we3=0 and s_in=0.
REQ-017 IO_WAIT SHALL hold io_sel and the strobe constant; in the first cycle with io_rdy[port_idx]=1 it SHALL complete the instruction exactly as in REQ-015/016, so the strobe overlaps rdy by exactly 1 cycle.
REQ-018 port_idx >= NPORTS SHALL be treated as port 0.
REQ-019 Opcode 111111 (halt), and every undefined 11xxxx opcode, SHALL go to HALT.
REQ-020 HALT and ERR SHALL be absorbing: all enables low, halted=1, left only by reset.
REQ-021 Outputs SHALL be a combinational decode of the state register, opcode, s_z and io_rdy; any output not listed for a state SHALL be 0.

Reset
REQ-022 With reset high at a clock edge: state=FETCH, sp_cnt=0, err=00, timeout counter=0.
REQ-023 While reset is high, all outputs SHALL be forced to 0 (including ir_en).
REQ-024 Reset SHALL abort IO_WAIT immediately; the strobe drops in the same cycle.

Configuration
REQ-025 With macro UC_IO_TIMEOUT_EN defined:
 - a counter SHALL clear on entry to IO_WAIT and increment each cycle in IO_WAIT;
 - on reaching TIMEOUT_CYCLES without rdy, the FSM SHALL go to ERR with err=11 and the strobe released.
REQ-026 Without UC_IO_TIMEOUT_EN: no counter SHALL exist, IO_WAIT SHALL wait indefinitely, and err=11 SHALL never occur.

Structure
REQ-027 Package uc_pkg SHALL hold:
 - the state enum;
 - opcode constants (OP_JMP, OP_JZ, OP_JNZ, OP_CALL, OP_RET, OP_IN, OP_OUT, OP_HALT);
 - the err code constants.
REQ-028 Sub-module uc_io_hs SHALL contain the handshake, the port select and the optional timeout; the FSM and decode SHALL stay in uc_mc_io.

Verification
REQ-029 Directed scenarios:
 - ALU 000100 -> ir_en at cycle 0; EXEC at cycle 2 with op_alu=001, we3=wez=pc_en=1.
 - Opcode 110001 with s_z=1 -> s_inc=0 in EXEC; with s_z=0 -> s_inc=1.
 - STACK_DEPTH=2: three calls -> the third gives ERR, err=01, no push; reset then a return -> err=10.
 - IN on port 2 with io_rdy[2] raised 5 cycles after EXEC -> io_rd and io_sel=0100 held for 6 cycles, then we3=s_in=pc_en=1 for 1 cycle.
 - UC_IO_TIMEOUT_EN with TIMEOUT_CYCLES=10, OUT and io_rdy never raised -> ERR, err=11, io_wr low, halted=1.
 - Reset asserted mid-IO_WAIT -> all outputs 0 in the same cycle; ir_en=1 in the first cycle after release.
